// File: rtl/sbox_share_sequencer.sv
// Issue/collect sequencer around the shared 3-share Midori64 S-box pipeline:
// serialises 16 nibbles per share into the chain and reassembles the results.
module sbox_share_sequencer #(
    parameter int unsigned SBOX_LAT = 2,
    parameter int unsigned NIB      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [191:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [11:0]  sbox_in,
    input  logic [11:0]  sbox_out,
    output logic [191:0] state_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [4:0] NIB_C  = 5'(NIB);
    localparam logic [4:0] LAST_C = 5'(NIB - 1);

    state_t            state_q;
    logic [191:0]      buf_q;
    logic [191:0]      state_out_q;
    logic [4:0]        issue_cnt_q;
    logic [4:0]        coll_cnt_q;
    logic [SBOX_LAT:0] vld_q;
    logic              busy_q;
    logic              done_q;
    logic [11:0]       sbox_in_q;

    logic              issue_en_d;
    logic              capture_d;
    logic              last_capture_d;
    logic [11:0]       first_nib_d;
    logic [11:0]       next_nib_d;
    logic [7:0]        cap_base_d;

    function automatic logic [11:0] lane_nib(input logic [191:0] st, input logic [3:0] k);
        logic [7:0] base;
        base = {2'b00, k, 2'b00};
        return {st[128 + base +: 4], st[64 + base +: 4], st[base +: 4]};
    endfunction

    assign first_nib_d    = lane_nib(state_in, 4'd0);
    assign next_nib_d     = lane_nib(buf_q, issue_cnt_q[3:0]);
    assign issue_en_d     = (issue_cnt_q < NIB_C);
    assign capture_d      = vld_q[SBOX_LAT] && (coll_cnt_q < NIB_C);
    assign last_capture_d = capture_d && (coll_cnt_q == LAST_C);
    assign cap_base_d     = {2'b00, coll_cnt_q[3:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            state_out_q <= '0;
            issue_cnt_q <= '0;
            coll_cnt_q  <= '0;
            vld_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sbox_in_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // Nibble 0 goes out straight from state_in at the accepting
                        // edge, so the issue counter starts at one nibble already sent.
                        buf_q       <= state_in;
                        sbox_in_q   <= first_nib_d;
                        issue_cnt_q <= 5'd1;
                        coll_cnt_q  <= '0;
                        vld_q       <= {{SBOX_LAT{1'b0}}, 1'b1};
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
                    end else begin
                        sbox_in_q   <= '0;
                        vld_q       <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                RUN: begin
                    vld_q <= {vld_q[SBOX_LAT-1:0], issue_en_d};
                    if (issue_en_d) begin
                        sbox_in_q   <= next_nib_d;
                        issue_cnt_q <= issue_cnt_q + 5'd1;
                    end else begin
                        sbox_in_q   <= '0;
                    end

                    if (capture_d) begin
                        for (int unsigned s = 0; s < 3; s++) begin
                            state_out_q[s*64 + cap_base_d +: 4] <= sbox_out[s*4 +: 4];
                        end
                        coll_cnt_q <= coll_cnt_q + 5'd1;
                    end

                    if (last_capture_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                default: begin
                    sbox_in_q <= '0;
                    vld_q     <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sbox_in   = sbox_in_q;
    assign state_out = state_out_q;

endmodule

// File: tb/tb_sbox_share_sequencer.sv
// Bench for sbox_share_sequencer: loopback pipelines of depth 1/2/4/8 plus a
// masked Midori Sb0 stand-in; expected states go through per-instance queues.
module tb_sbox_share_sequencer;

    localparam logic [191:0] ST_A = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic         start_a [5];
    logic [191:0] sin_a   [5];
    logic         busy_a  [5];
    logic         done_a  [5];
    logic [11:0]  sbin_a  [5];
    logic [191:0] sout_a  [5];

    logic [191:0] exp_q [5][$];
    logic [11:0]  seq_log [40];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [3:0] sb4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'hA; 4'h2: return 4'hD; 4'h3: return 4'h3;
            4'h4: return 4'hE; 4'h5: return 4'hB; 4'h6: return 4'hF; 4'h7: return 4'h7;
            4'h8: return 4'h8; 4'h9: return 4'h9; 4'hA: return 4'h1; 4'hB: return 4'h5;
            4'hC: return 4'h0; 4'hD: return 4'h2; 4'hE: return 4'h4; default: return 4'h6;
        endcase
    endfunction

    function automatic logic [63:0] sb64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sb4(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [11:0] masked_sb(input logic [11:0] v, input logic [3:0] m1, input logic [3:0] m2);
        logic [3:0] y;
        y = sb4(v[3:0] ^ v[7:4] ^ v[11:8]);
        return {m2, m1, y ^ m1 ^ m2};
    endfunction

    function automatic logic [11:0] nib(input logic [191:0] st, input int k);
        if (k > 15) return 12'h000;
        return {st[128 + 4*k +: 4], st[64 + 4*k +: 4], st[4*k +: 4]};
    endfunction

    function automatic logic [191:0] rand192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Loopback instances: a plain register chain; outside the 16-cycle issue
    // window the chain is fed garbage so stray captures would show up.
    for (genvar g = 0; g < 4; g++) begin : g_lb
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
        logic [11:0] pipe [L];
        int unsigned win = 100;
        always @(posedge clk) begin
            if (start_a[g] && !busy_a[g]) win <= 0;
            else if (win < 100) win <= win + 1;
            pipe[0] <= (win < 16) ? sbin_a[g] : 12'($urandom);
            for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
        end
        sbox_share_sequencer #(.SBOX_LAT(L)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_a[g]), .state_in(sin_a[g]),
            .busy(busy_a[g]), .done(done_a[g]), .sbox_in(sbin_a[g]),
            .sbox_out(pipe[L-1]), .state_out(sout_a[g])
        );
    end

    logic [11:0] sp1, sp2;
    int unsigned win4 = 100;
    always @(posedge clk) begin
        if (start_a[4] && !busy_a[4]) win4 <= 0;
        else if (win4 < 100) win4 <= win4 + 1;
        sp1 <= (win4 < 16) ? masked_sb(sbin_a[4], 4'($urandom), 4'($urandom)) : 12'($urandom);
        sp2 <= sp1;
    end

    sbox_share_sequencer #(.SBOX_LAT(2)) u_dut_sb (
        .clk(clk), .rst_n(rst_n), .start(start_a[4]), .state_in(sin_a[4]),
        .busy(busy_a[4]), .done(done_a[4]), .sbox_in(sbin_a[4]),
        .sbox_out(sp2), .state_out(sout_a[4])
    );

    task automatic launch(input int g, input logic [191:0] st);
        start_a[g] = 1'b1;
        sin_a[g]   = st;
        if (g == 4) exp_q[g].push_back({128'b0, sb64(st[63:0] ^ st[127:64] ^ st[191:128])});
        else        exp_q[g].push_back(st);
        @(posedge clk);
        #1;
        start_a[g] = 1'b0;
        sin_a[g]   = rand192();
    endtask

    // n = cycle index (0 = cycle after the accepting edge) where done is seen, -1 on timeout
    task automatic wait_done(input int g, input int limit, output int n, output int bb);
        n  = -1;
        bb = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (c < 40) seq_log[c] = sbin_a[g];
            if (done_a[g]) begin
                if (busy_a[g] !== 1'b0) bb++;
                n = c;
                break;
            end
            if (busy_a[g] !== 1'b1) bb++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (busy_a[g] !== 1'b0 || done_a[g] !== 1'b0 || sbin_a[g] !== 12'h0 || sout_a[g] !== 192'h0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: busy=%b done=%b sbox_in=%h state_out=%h, want all zero",
                         g, busy_a[g], done_a[g], sbin_a[g], sout_a[g]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        int n, bb, bad;
        logic [191:0] e;
        launch(1, ST_A);
        wait_done(1, 60, n, bb);
        n_checks++;
        if (n !== 18) begin n_fail++; $display("FAIL lb_done_cycle: got %0d want 18", n); end
        n_checks++;
        if (bb !== 0) begin n_fail++; $display("FAIL lb_busy: %0d bad busy cycles, want 0", bb); end
        n_checks++;
        if (seq_log[0] !== 12'hF0F) begin n_fail++; $display("FAIL lb_nib0: got %h want f0f", seq_log[0]); end
        n_checks++;
        if (seq_log[1] !== nib(ST_A, 1)) begin n_fail++; $display("FAIL lb_nib1: got %h want %h", seq_log[1], nib(ST_A, 1)); end
        bad = 0;
        for (int c = 0; c <= 18; c++) if (seq_log[c] !== nib(ST_A, c)) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL lb_sbox_in_seq: %0d wrong cycles, want 0", bad); end
        e = exp_q[1].pop_front();
        n_checks++;
        if (sout_a[1] !== e) begin n_fail++; $display("FAIL lb_state_out: got %h want %h", sout_a[1], e); end
        @(negedge clk);
        n_checks++;
        if (done_a[1] !== 1'b0 || busy_a[1] !== 1'b0) begin
            n_fail++; $display("FAIL lb_done_pulse: done=%b busy=%b want 0 0", done_a[1], busy_a[1]);
        end
    endtask

    task automatic test_sbox();
        int n, bb;
        logic [63:0] x0, x1, x2, got;
        logic [191:0] e;
        for (int r = 0; r < 2; r++) begin
            x0 = {$urandom, $urandom};
            x1 = {$urandom, $urandom};
            x2 = (r == 0) ? (x0 ^ x1) : {$urandom, $urandom};
            launch(4, {x2, x1, x0});
            wait_done(4, 60, n, bb);
            n_checks++;
            if (n !== 18) begin n_fail++; $display("FAIL sb_done_cycle[%0d]: got %0d want 18", r, n); end
            e   = exp_q[4].pop_front();
            got = sout_a[4][63:0] ^ sout_a[4][127:64] ^ sout_a[4][191:128];
            n_checks++;
            if (got !== e[63:0]) begin n_fail++; $display("FAIL sb_xor[%0d]: got %h want %h", r, got, e[63:0]); end
            if (r == 0) begin
                n_checks++;
                if (got !== 64'hCCCCCCCCCCCCCCCC) begin
                    n_fail++; $display("FAIL sb_zero: got %h want cccccccccccccccc", got);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, bb;
        logic [191:0] sb, sc, e;
        sb = rand192();
        sc = rand192();
        launch(1, sb);
        wait_done(1, 60, n1, bb);
        n_checks++;
        if (n1 !== 18) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 18", n1); end
        e = exp_q[1].pop_front();
        n_checks++;
        if (sout_a[1] !== e) begin n_fail++; $display("FAIL b2b_first_result: got %h want %h", sout_a[1], e); end
        launch(1, sc);
        wait_done(1, 60, n2, bb);
        n_checks++;
        if (n2 + 1 !== 19) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 19", n2 + 1); end
        n_checks++;
        if (bb !== 0) begin n_fail++; $display("FAIL b2b_busy: %0d bad busy cycles, want 0", bb); end
        e = exp_q[1].pop_front();
        n_checks++;
        if (sout_a[1] !== e) begin n_fail++; $display("FAIL b2b_second_result: got %h want %h", sout_a[1], e); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int dones, first;
        logic [191:0] snap, e;
        dones = 0;
        first = -1;
        snap  = '0;
        launch(1, ST_A);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 4) begin start_a[1] = 1'b1; sin_a[1] = rand192(); end
            if (c == 5) start_a[1] = 1'b0;
            if (done_a[1]) begin
                dones++;
                if (first < 0) begin first = c; snap = sout_a[1]; end
            end
        end
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d want 1", dones); end
        n_checks++;
        if (first !== 18) begin n_fail++; $display("FAIL busy_start_done_cycle: got %0d want 18", first); end
        e = exp_q[1].pop_front();
        n_checks++;
        if (snap !== e) begin n_fail++; $display("FAIL busy_start_result: got %h want %h", snap, e); end
        n_checks++;
        if (sout_a[1] !== e) begin n_fail++; $display("FAIL busy_start_stable: got %h want %h", sout_a[1], e); end
    endtask

    task automatic test_reset_mid();
        int n, bb, dones;
        logic [191:0] sc, e;
        @(negedge clk);
        launch(1, ST_A);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy_a[1] !== 1'b0 || done_a[1] !== 1'b0 || sbin_a[1] !== 12'h0 || sout_a[1] !== 192'h0) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b done=%b sbox_in=%h state_out=%h, want all zero",
                     busy_a[1], done_a[1], sbin_a[1], sout_a[1]);
        end
        exp_q[1].delete();
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a[1] !== 1'b0) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d done cycles want 0", dones); end
        sc = rand192();
        launch(1, sc);
        wait_done(1, 60, n, bb);
        n_checks++;
        if (n !== 18) begin n_fail++; $display("FAIL midreset_rerun_cycle: got %0d want 18", n); end
        e = exp_q[1].pop_front();
        n_checks++;
        if (sout_a[1] !== e) begin n_fail++; $display("FAIL midreset_rerun_result: got %h want %h", sout_a[1], e); end
        @(negedge clk);
    endtask

    task automatic test_lat_sweep();
        int gs [3] = '{0, 2, 3};
        int ls [3] = '{1, 4, 8};
        int n, bb;
        logic [191:0] e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            launch(gs[i], rand192());
            wait_done(gs[i], 80, n, bb);
            n_checks++;
            if (n !== 16 + ls[i]) begin
                n_fail++; $display("FAIL sweep_done_cycle[L=%0d]: got %0d want %0d", ls[i], n, 16 + ls[i]);
            end
            e = exp_q[gs[i]].pop_front();
            n_checks++;
            if (sout_a[gs[i]] !== e) begin
                n_fail++; $display("FAIL sweep_result[L=%0d]: got %h want %h", ls[i], sout_a[gs[i]], e);
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 5; g++) begin
            start_a[g] = 1'b0;
            sin_a[g]   = '0;
        end
        test_reset();
        test_loopback();
        test_sbox();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        test_lat_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
